// File: rtl/min_max_scan_controller.sv
// Block min/max scanner: streams BLOCK_LENGTH unsigned bytes through one shared
// 8-bit comparator, reporting extremes and first-occurrence indices per block.

module comparator_8bit (
   input  logic       Reset_In,
   input  logic [7:0] A_In,
   input  logic [7:0] B_In,
   output logic       A_Less_Than_B,
   output logic       A_Greater_Than_B
);

   // Reset forces both flags low so no result register can load during reset.
   always_comb begin
      A_Less_Than_B    = 1'b0;
      A_Greater_Than_B = 1'b0;
      if (!Reset_In) begin
         A_Less_Than_B    = (A_In < B_In);
         A_Greater_Than_B = (A_In > B_In);
      end
   end

endmodule

module min_max_scan_controller #(
   parameter int unsigned BLOCK_LENGTH = 8
) (
   input  logic       Clock_In,
   input  logic       Reset_In,
   input  logic       Start_In,
   input  logic [7:0] Data_In,
   input  logic       Data_Valid_In,
   output logic       Data_Ready_Out,
   output logic       Busy_Out,
   output logic       Done_Out,
   output logic [7:0] Min_Out,
   output logic [7:0] Max_Out,
   output logic [7:0] Min_Index_Out,
   output logic [7:0] Max_Index_Out
);

   localparam logic [7:0] LAST_IDX = 8'(BLOCK_LENGTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_CMP_MIN,
      ST_CMP_MAX,
      ST_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic [7:0] sample_q, sample_d;
   logic [7:0] min_q, min_d;
   logic [7:0] max_q, max_d;
   logic [7:0] min_idx_q, min_idx_d;
   logic [7:0] max_idx_q, max_idx_d;

   logic [7:0] cmp_b;
   logic       cmp_lt;
   logic       cmp_gt;

   // Operand B selects the running extreme being challenged this cycle.
   always_comb begin
      cmp_b = min_q;
      if (state_q == ST_CMP_MAX) begin
         cmp_b = max_q;
      end
   end

   comparator_8bit u_cmp (
      .Reset_In         (Reset_In),
      .A_In             (sample_q),
      .B_In             (cmp_b),
      .A_Less_Than_B    (cmp_lt),
      .A_Greater_Than_B (cmp_gt)
   );

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      sample_d  = sample_q;
      min_d     = min_q;
      max_d     = max_q;
      min_idx_d = min_idx_q;
      max_idx_d = max_idx_q;

      case (state_q)
         ST_IDLE: begin
            if (Start_In) begin
               state_d = ST_ACCEPT;
               count_d = '0;
            end
         end

         ST_ACCEPT: begin
            if (Data_Valid_In) begin
               sample_d = Data_In;
               if (count_q == '0) begin
                  min_d     = Data_In;
                  max_d     = Data_In;
                  min_idx_d = '0;
                  max_idx_d = '0;
                  if (BLOCK_LENGTH == 1) begin
                     state_d = ST_DONE;
                  end else begin
                     count_d = count_q + 8'd1;
                  end
               end else begin
                  state_d = ST_CMP_MIN;
               end
            end
         end

         ST_CMP_MIN: begin
            if (cmp_lt) begin
               min_d     = sample_q;
               min_idx_d = count_q;
            end
            state_d = ST_CMP_MAX;
         end

         ST_CMP_MAX: begin
            if (cmp_gt) begin
               max_d     = sample_q;
               max_idx_d = count_q;
            end
            if (count_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               count_d = count_q + 8'd1;
               state_d = ST_ACCEPT;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         sample_q  <= '0;
         min_q     <= '0;
         max_q     <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         sample_q  <= sample_d;
         min_q     <= min_d;
         max_q     <= max_d;
         min_idx_q <= min_idx_d;
         max_idx_q <= max_idx_d;
      end
   end

   assign Data_Ready_Out = (state_q == ST_ACCEPT);
   assign Busy_Out       = (state_q == ST_ACCEPT) || (state_q == ST_CMP_MIN) ||
                           (state_q == ST_CMP_MAX);
   assign Done_Out       = (state_q == ST_DONE);
   assign Min_Out        = min_q;
   assign Max_Out        = max_q;
   assign Min_Index_Out  = min_idx_q;
   assign Max_Index_Out  = max_idx_q;

endmodule

// File: doc/min_max_scan_controller.md
# min_max_scan_controller

Sequencing controller that streams a block of BLOCK_LENGTH unsigned 8-bit samples through a single shared instance of the team's 8-bit comparator. It reports the block minimum and maximum, and the index of each, after the last sample. The comparator is time-multiplexed: one compare against the running minimum, then one against the running maximum, per sample. The block sits between a byte-stream source and any consumer that needs block extremes, such as peak detect or auto-ranging.

## Interface

- BLOCK_LENGTH, 8, samples per scan; legal range 1..255.

- Clock_In  input  1  rising-edge clock.
- Reset_In  input  1  synchronous, active-high reset. Also drives the internal comparator's Reset_In.
- Start_In  input  1  begin a scan. Sampled only in IDLE.
- Data_In  input  8  unsigned sample.
- Data_Valid_In  input  1  Data_In valid.
- Data_Ready_Out  output  1  block can accept a sample. Decoded from state: high only in ACCEPT.
- Busy_Out  output  1  high in ACCEPT, CMP_MIN and CMP_MAX.
- Done_Out  output  1  one-cycle pulse; high only in DONE.
- Min_Out  output  8  block minimum.
- Max_Out  output  8  block maximum.
- Min_Index_Out  output  8  index of the first occurrence of the minimum (0-based).
- Max_Index_Out  output  8  index of the first occurrence of the maximum (0-based).

## Operation

- States: IDLE, ACCEPT, CMP_MIN, CMP_MAX, DONE.
- IDLE:
  - Start_In=1 moves to ACCEPT and clears the sample counter to 0.
  - Start_In=0 holds IDLE.
- ACCEPT: a handshake is the edge with Data_Valid_In & Data_Ready_Out. The sample is captured into the sample register.
  - Counter = 0: load Min_Out = Max_Out = Data_In and both indices = 0.
    - If BLOCK_LENGTH = 1, go to DONE.
    - Otherwise increment the counter and stay in ACCEPT.
  - Counter > 0: go to CMP_MIN.
  - No handshake: hold ACCEPT indefinitely. Valid gaps are legal.
- CMP_MIN: comparator A = sample register, B = Min_Out.
  - If A_Less_Than_B, load Min_Out = sample and Min_Index_Out = counter.
  - Go to CMP_MAX.
- CMP_MAX: comparator A = sample register, B = Max_Out.
  - If A_Greater_Than_B, load Max_Out = sample and Max_Index_Out = counter.
  - If counter = BLOCK_LENGTH-1, go to DONE; otherwise increment the counter and go to ACCEPT.
- DONE: Done_Out=1 for one cycle, then unconditionally IDLE.
- Comparisons are strict, so ties keep the earlier index.
- All comparison decisions come from the shared comparator outputs. There is no second magnitude comparator in this block.
- Results hold from DONE until the first sample of the next scan is loaded.
- Start_In outside IDLE is ignored, including in the DONE cycle.
- Data_In is ignored outside a handshake.
- Counter width is 8 bits. It never exceeds BLOCK_LENGTH-1, so no wrap occurs.

## Timing

- Reset values (edge with Reset_In=1, from any state):
  - state IDLE;
  - counter 0;
  - Min_Out, Max_Out, Min_Index_Out, Max_Index_Out = 0x00;
  - Data_Ready_Out, Busy_Out, Done_Out = 0.
- A reset mid-scan aborts the scan: no Done_Out pulse, and partial results are discarded.
- Reset takes priority over every other event on the same edge.
- With Start sampled at edge 0 and Data_Valid_In held high:
  - sample 0 is accepted at edge 1;
  - sample i (i≥1) is accepted at edge 3i-1;
  - CMP_MIN resolves at edge 3i;
  - CMP_MAX resolves at edge 3i+1.
- DONE is entered at edge 3·BLOCK_LENGTH-2, so Done_Out is high in the following cycle. For BLOCK_LENGTH=1, DONE is entered at edge 1.
- Sustained throughput is one sample per 3 cycles. Each cycle of valid gap in ACCEPT adds exactly one cycle of latency.
- Results are valid in the Done_Out cycle and remain stable afterwards.
- The earliest next Start is sampled in the IDLE cycle immediately after DONE.

## Test plan

- Reset:
  - Hold Reset_In for 2 cycles → all outputs 0, Data_Ready_Out=0.
  - Start_In=1 during reset → ignored.
- Basic scan, BLOCK_LENGTH=8:
  - Samples 0x10,0x80,0x05,0xFF,0x05,0x33,0x00,0x7F with continuous valid → Done_Out high in the cycle after edge 22.
  - Min_Out=0x00, Min_Index_Out=6, Max_Out=0xFF, Max_Index_Out=3.
- Ties:
  - All eight samples 0x42 → Min=Max=0x42, both indices 0.
  - Samples 0x09,0x01,0x01,0x09 (BLOCK_LENGTH=4) → Min_Index=1, Max_Index=0.
- Valid gaps:
  - Insert 0–4 idle cycles at random between samples → same results as the continuous case.
  - Done edge = 22 + total gap cycles.
  - Data_Ready_Out never high outside ACCEPT.
- Start during a scan and reset mid-scan:
  - Pulse Start_In during sample 3 → no effect.
  - Assert Reset_In after sample 4 → outputs 0 next cycle, no Done_Out.
  - A new Start then scans correctly.
- BLOCK_LENGTH=1:
  - Sample 0xA5 → Done_Out in the cycle after edge 1.
  - Min=Max=0xA5, indices 0, no CMP states visited.
